// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, BCD-to-segment decode and button debounce state encoding.
// Segments are active-low, bit order g..a.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        HOLD = 2'd3
    } btn_state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_btn_pulse.sv
// Active-low button -> 2-FF synchroniser -> debounce FSM -> single-cycle pulse.
// Pulse appears 2 + DEBOUNCE_CYC cycles after the press reaches the input; holding never repeats.
module btn_pulse
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic pulse_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_DONE = CW'(DEBOUNCE_CYC);

    logic [1:0]    sync_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed;

    assign pressed = ~sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    cnt_d   = CNT_ONE;
                    state_d = (CNT_ONE == CNT_DONE) ? FIRE : ARM;
                end
            end
            ARM: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                    state_d = FIRE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIRE: begin
                pulse_o = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!pressed) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown with self-generated tick, reload-on-expiry, debounced +/- buttons, registered 7-seg.
// count_bcd_o is registered; hex_o lags it by one cycle. Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_countdown_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int PERIOD       = 20,
    parameter int TICK_DIV     = 16000000,
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pause_i,
    input  logic                    count_up_i,
    input  logic                    count_dn_i,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic [4*NUM_DIGITS-1:0] count_bcd_o,
    output logic                    expire_o
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int DW = $clog2(TICK_DIV);

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [CW-1:0] PERIOD_BCD = to_bcd(PERIOD);
    localparam logic [CW-1:0] ALL_NINES  = to_bcd(10**NUM_DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 6 || PERIOD < 0 || PERIOD > 10**NUM_DIGITS - 1 ||
        TICK_DIV < 2 || DEBOUNCE_CYC < 1) begin : g_bad_params
        $error("bcd_countdown_timer: parameter out of range");
    end

    logic [DW-1:0]           div_q, div_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    expire_q, expire_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [CW-1:0]           cnt_tick;
    logic                    tick;
    logic                    up_pulse, dn_pulse;

    btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (count_up_i),
        .pulse_o (up_pulse)
    );

    btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (count_dn_i),
        .pulse_o (dn_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            cnt_q    <= PERIOD_BCD;
            expire_q <= 1'b0;
            hex_q    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
            hex_q    <= hex_d;
        end
    end

    // Tick is resolved first; the button adjustment then saturates on the post-tick value.
    always_comb begin
        div_d    = div_q;
        tick     = 1'b0;
        expire_d = 1'b0;
        if (!pause_i) begin
            if (div_q == DIV_LAST) begin
                tick  = 1'b1;
                div_d = '0;
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        cnt_tick = cnt_q;
        if (tick) begin
            if (cnt_q == '0) begin
                cnt_tick = PERIOD_BCD;
                expire_d = 1'b1;
            end else begin
                cnt_tick = bcd_dec(cnt_q);
            end
        end

        cnt_d = cnt_tick;
        if (up_pulse && !dn_pulse && cnt_tick != ALL_NINES) begin
            cnt_d = bcd_inc(cnt_tick);
        end else if (dn_pulse && !up_pulse && cnt_tick != '0) begin
            cnt_d = bcd_dec(cnt_tick);
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead  = 1'b1;
        hex_d = {NUM_DIGITS{SEG_BLANK}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (cnt_q[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
            hex_d[7*i +: 7] = lead ? SEG_BLANK : bcd_to_seg(cnt_q[4*i +: 4]);
        end
`else
        hex_d = {NUM_DIGITS{SEG_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = bcd_to_seg(cnt_q[4*i +: 4]);
        end
`endif
    end

    assign count_bcd_o = cnt_q;
    assign expire_o    = expire_q;
    assign hex_o       = hex_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomised scoreboard bench for bcd_countdown_timer (2 digits, PERIOD 20, TICK_DIV 4, DEBOUNCE_CYC 3).
module tb_bcd_countdown_timer;

    localparam int ND   = 2;
    localparam int PER  = 20;
    localparam int TDIV = 4;
    localparam int DEB  = 3;
    localparam int MAXV = 10**ND - 1;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        pause_i    = 1'b0;
    logic        count_up_i = 1'b1;
    logic        count_dn_i = 1'b1;
    logic [13:0] hex_o;
    logic [7:0]  count_bcd_o;
    logic        expire_o;

    bcd_countdown_timer #(
        .NUM_DIGITS   (ND),
        .PERIOD       (PER),
        .TICK_DIV     (TDIV),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pause_i     (pause_i),
        .count_up_i  (count_up_i),
        .count_dn_i  (count_dn_i),
        .hex_o       (hex_o),
        .count_bcd_o (count_bcd_o),
        .expire_o    (expire_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic        ex;
        logic [13:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: integer count, count of unpaused cycles, raw press history per button.
    int          m_cnt = PER;
    int          m_n   = 0;
    logic [15:0] hu    = '0;
    logic [15:0] hd    = '0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic logic [13:0] hex_of(input int c);
        logic [6:0] hi;
        hi = seg(c / 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (c / 10 == 0) hi = 7'h7f;
`endif
        return {hi, seg(c % 10)};
    endfunction

    function automatic logic [7:0] bcd_of(input int c);
        logic [7:0] r;
        r[7:4] = 4'(c / 10);
        r[3:0] = 4'(c % 10);
        return r;
    endfunction

    // A press registers once its synchronised run of pressed samples first reaches DEB;
    // the adjustment lands three edges after the last of those raw samples.
    function automatic logic fired(input logic [15:0] h);
        for (int j = 0; j < DEB; j++) begin
            if (!h[3+j]) return 1'b0;
        end
        return !h[3+DEB];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs, push the expected post-edge state, advance to the next sampling point.
    task automatic step(input logic rst, input logic up, input logic dn, input logic ps);
        exp_t e;
        logic pu, pd, tick;
        rst_n      = rst;
        count_up_i = ~up;
        count_dn_i = ~dn;
        pause_i    = ps;
        if (!rst) begin
            m_cnt = PER;
            m_n   = 0;
            hu    = '0;
            hd    = '0;
            e.cnt = PER;
            e.ex  = 1'b0;
            e.hex = 14'h3fff;
        end else begin
            e.hex = hex_of(m_cnt);
            hu    = {hu[14:0], up};
            hd    = {hd[14:0], dn};
            pu    = fired(hu);
            pd    = fired(hd);
            tick  = 1'b0;
            if (!ps) begin
                tick = (m_n % TDIV) == TDIV - 1;
                m_n++;
            end
            e.ex = 1'b0;
            if (tick) begin
                if (m_cnt == 0) begin
                    m_cnt = PER;
                    e.ex  = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            if (pu && !pd && m_cnt < MAXV) m_cnt = m_cnt + 1;
            else if (pd && !pu && m_cnt > 0) m_cnt = m_cnt - 1;
            e.cnt = m_cnt;
        end
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_phase(input int cycles);
        int   t, mode, on, off;
        logic ps;
        t  = 0;
        ps = 1'b0;
        while (t < cycles) begin
            mode = $urandom_range(0, 3);
            on   = $urandom_range(1, 9);
            off  = $urandom_range(2, 6);
            for (int i = 0; i < on + off; i++) begin
                if ($urandom_range(0, 9) == 0) ps = ~ps;
                step(1'b1, (i < on) && mode[0], (i < on) && mode[1], ps);
            end
            t = t + on + off;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_bcd", 32'(count_bcd_o), 32'(bcd_of(e.cnt)));
            chk("expire", 32'(expire_o), 32'(e.ex));
            chk("hex", 32'(hex_o), 32'(e.hex));
        end
    end

    initial begin : driver
        int t;
        @(negedge clk);
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (90) step(1'b1, 1'b0, 1'b0, 1'b0);
        rand_phase(600);

        for (int k = 0; k < 110; k++) begin
            repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1);
            repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_up_99", 32'(count_bcd_o), 32'h99);

        for (int k = 0; k < 110; k++) begin
            repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
            repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_dn_0", 32'(count_bcd_o), 32'h00);
        chk("sat_dn_no_expire", 32'(expire_o), 32'h0);

        // Line the up-pulse up with the first tick after unpausing at count 0.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        t = (TDIV - 1) - (m_n % TDIV);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, (i >= 5 - t) ? 1'b0 : 1'b1);
            if (i == 5) begin
                chk("tick_plus_up_count", 32'(count_bcd_o), 32'h21);
                chk("tick_plus_up_expire", 32'(expire_o), 32'h1);
            end
        end
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_arm_count", 32'(count_bcd_o), 32'h20);
        chk("rst_mid_arm_hex", 32'(hex_o), 32'h3fff);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0, 1'b0, 1'b0);

        rand_phase(1500);

        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_count", 32'(count_bcd_o), 32'h20);
        chk("rst_mid_hex", 32'(hex_o), 32'h3fff);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0, 1'b0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised N-digit BCD countdown timer with pause, debounced count-up/count-down buttons and registered active-low 7-segment outputs. Sits between the board clock/buttons/switches and the HEX displays, and is the generalised successor of the fixed two-digit lab countdown. It generates its own one-second tick from `clk`, reloads on expiry, and flags each expiry with a one-cycle pulse.

## Interface
- `NUM_DIGITS`, 2, number of BCD digits and HEX displays (1–6)
- `PERIOD`, 20, reload value in decimal; elaboration error if > 10^NUM_DIGITS−1
- `TICK_DIV`, 16000000, `clk` cycles per countdown tick (≥ 2)
- `DEBOUNCE_CYC`, 3, consecutive synchronised "pressed" samples required before a button registers (≥ 1)
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pause`  in  1  level switch; 1 freezes tick divider and countdown
- `count_up`  in  1  active-low push button; +1 per press
- `count_dn`  in  1  active-low push button; −1 per press
- `hex`  out  7*NUM_DIGITS  segments, active-low; digit i at [7i+6:7i], bit order g..a
- `count_bcd`  out  4*NUM_DIGITS  current count, BCD, digit i at [4i+3:4i]
- `expire`  out  1  one-cycle pulse when count reloads from 0

## Operation
- Tick divider: counts 0..TICK_DIV−1 while `pause`=0; tick asserted in the cycle it equals TICK_DIV−1, then wraps to 0. Holds value while `pause`=1.
- On tick: count==0 → count=PERIOD, `expire`=1 for that cycle; else count−1 (BCD borrow across digits).
- Each button passes through a 2-FF synchroniser and a debounce FSM:
  - IDLE: sample pressed → ARM, counter=1.
  - ARM: pressed → counter+1; counter reaching DEBOUNCE_CYC → FIRE; released → IDLE.
  - FIRE: single-cycle adjust pulse; → HOLD.
  - HOLD: released → IDLE; held indefinitely yields no further pulses.
- Adjust: up pulse → count+1, saturating at 10^NUM_DIGITS−1; down pulse → count−1, saturating at 0 (no reload, no `expire`).
- Buttons work while paused.
- Up and down pulses in the same cycle: both ignored.
- Tick and adjust pulse in the same cycle: tick rule applied first, then adjust to that result with saturation; `expire` still fires if reload occurred.
- `hex` = registered 7-segment decode of `count_bcd`; values 0–9 only, any other nibble decodes to blank 7'h7f.

## Timing
- Reset values: count=PERIOD, divider=0, button FSMs IDLE, `expire`=0, `hex`=all 7'h7f (blank).
- `count_bcd` is a register output; `hex` follows `count_bcd` with one cycle of latency. First edge after reset release shows PERIOD.
- Button press to count change: 2 (sync) + DEBOUNCE_CYC + 1 cycles.
- `pause` is sampled directly; it takes effect in the same cycle (a tick coinciding with `pause`=1 is suppressed).
- Reset mid-debounce or mid-count returns all state to reset values immediately.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digits above the most significant non-zero digit display 7'h7f; digit 0 is always shown (count 0 shows "0"). `count_bcd` is unaffected.
- Not defined: all NUM_DIGITS digits are always displayed, including leading zeros.

## Structure
- Shared package `seg7_pkg`: `SEG_BLANK`=7'h7f, digit-to-segment constants 0–9, a `bcd_to_seg` function, and the button FSM state enum (IDLE, ARM, FIRE, HOLD).
- Sub-module `btn_pulse` (synchroniser + debounce FSM + one-shot output), instantiated once per button; parameter DEBOUNCE_CYC.

## Test plan
Use NUM_DIGITS=2, PERIOD=20, TICK_DIV=4, DEBOUNCE_CYC=3.
- Reset, run 80 cycles → count 20→0 at one step per 4 cycles, then 20 with `expire` high for exactly one cycle; `hex` lags `count_bcd` by 1 cycle.
- Count 10, decrement → 09 (BCD borrow); with LEADING_ZERO_BLANK_EN, hex[13:7]=7'h7f, hex[6:0]=7'b0010000.
- `pause`=1 for 20 cycles → count and divider frozen; `pause`=0 → resumes with no tick lost or doubled.
- `count_up` low for 2 cycles then high → no change; low for 10 cycles → exactly one +1 after 2+3+1 cycles; at 99, up → stays 99; at 0, down → stays 0 with no `expire`.
- Up and down pulses coincident → count unchanged; up pulse coincident with tick at count 0 → count 21, `expire`=1.
- Assert `rst_n`=0 mid-ARM and mid-countdown → count=20, `hex` blank, no adjust pulse after release.
